// File: rtl/padder_576.sv
// padder_576: assembles 64-bit message words into 576-bit SHA3-512 rate blocks with SHA3 padding
module padder_576 (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [63:0]  i_in,
    input  logic         i_in_ready,
    input  logic         i_is_last,
    input  logic [2:0]   i_byte_num,
    input  logic         i_f_ack,
    output logic         o_buffer_full,
    output logic [575:0] o_out,
    output logic         o_out_ready,
    output logic         o_last_block
);
    typedef enum logic [1:0] {ABSORB, PAD, FULL} state_t;
    state_t         r_state;
    logic [3:0]     r_cnt;
    logic [575:0]   r_buf;
    logic           r_final;
    logic           w_tail;
    logic [63:0]    w_keep;
    logic [63:0]    w_word;
    // the next word to enter the buffer lands in slot 9
    assign w_tail = r_cnt == 4'd8;
    // host bytes 0..byte_num-1 survive; the 0x06 domain byte sits right after them (7-b == ~b)
    assign w_keep = ~(64'hFFFF_FFFF_FFFF_FFFF >> {i_byte_num, 3'b000});
    assign w_word = !i_is_last ? i_in
                  : (i_in & w_keep) | (64'h06 << {~i_byte_num, 3'b000}) | {56'd0, w_tail, 7'd0};
    // handshake outputs come straight from registered state, no path from in_ready or f_ack
    assign o_out         = r_buf;
    assign o_buffer_full = r_state == FULL;
    assign o_out_ready   = r_state == FULL;
    assign o_last_block  = r_state == FULL && r_final;
    // absorb host words, zero-fill with the closing 0x80 word, hold the block until acked
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ABSORB;
            r_cnt   <= 4'd0;
            r_buf   <= '0;
            r_final <= 1'b0;
        end else begin
            case (r_state)
                ABSORB: if (i_in_ready) begin
                    r_buf <= {r_buf[511:0], w_word};
                    r_cnt <= r_cnt + 4'd1;
                    if (w_tail) begin
                        r_state <= FULL;
                        r_final <= i_is_last;
                    end else if (i_is_last) begin
                        r_state <= PAD;
                        r_final <= 1'b1;
                    end
                end
                PAD: begin
                    r_buf <= {r_buf[511:0], w_tail ? 64'h80 : 64'h0};
                    r_cnt <= r_cnt + 4'd1;
                    if (w_tail) r_state <= FULL;
                end
                FULL: if (i_f_ack) begin
                    r_state <= ABSORB;
                    r_cnt   <= 4'd0;
                    r_buf   <= '0;
                    r_final <= 1'b0;
                end
                default: r_state <= ABSORB;
            endcase
        end
    end
endmodule

// File: doc/padder_576.md
# padder_576

Message-input sequencer for the high-throughput SHA3-512 (rate 576 bits) hash path. It accepts 64-bit message words from the host and assembles them into 576-bit rate blocks. It applies SHA3 padding (domain byte 0x06, final bit 0x80) on the last word and presents each full block to the permutation core under a ready/ack handshake. It sits between the host interface and the f_permutation block.

## Interface
Parameters: none (rate fixed at 576 bits = 9 words × 64 bits).

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in  in  64  message word; byte 0 of the word is in[63:56] (big-endian within word)
- in_ready  in  1  host strobe: `in` valid this cycle
- is_last  in  1  qualifies in_ready: this word is the final (partial) word
- byte_num  in  3  valid bytes in the last word, 0..7; meaningful only with is_last
- f_ack  in  1  permutation core has consumed the current block
- buffer_full  out  1  block holds 9 words; host must not present words
- out  out  576  assembled block; first-accepted word in out[575:512], last in out[63:0]
- out_ready  out  1  block valid for permutation core
- last_block  out  1  valid with out_ready: block is the final block of the message

## Operation
- State: 4-bit word count `cnt` (0..9), 576-bit shift buffer, FSM {ABSORB, PAD, FULL}, `final` flag.
- ABSORB: word accepted when in_ready && !buffer_full; buffer <= {buffer[511:0], w}; cnt+1.
  - Non-last word: w = in.
  - Last word (is_last=1): w = in bytes 0..byte_num-1 kept, byte byte_num = 0x06, lower bytes 0. byte_num=0 gives w = 64'h0600000000000000, and `in` is ignored.
  - If the accepted word makes cnt=9: also OR 0x80 into w[7:0] when last. Go to FULL with final=is_last.
  - Else if last: go to PAD with final=1.
- PAD: one zero word shifted in per cycle, ignoring host inputs. The word that makes cnt=9 is 64'h80. Go to FULL.
- FULL: buffer_full=out_ready=1, last_block=final. On f_ack: cnt=0, final=0, buffer cleared, go to ABSORB.
- Messages whose length is a multiple of 8 bytes end with an is_last word with byte_num=0. If that word lands in slot 9, the low byte is 0x86 only for byte_num=7. Otherwise the 0x06 byte and 0x80 byte are distinct.
- f_ack outside FULL is ignored. in_ready in PAD or FULL is ignored (word dropped). Host is required to honour buffer_full.
- byte_num is a 3-bit value, so overflow is impossible.

## Timing
- Reset values: out=0, out_ready=0, buffer_full=0, last_block=0, FSM=ABSORB, cnt=0. Reset asserted mid-block or mid-PAD discards the block immediately.
- buffer_full, out_ready and last_block are decoded from registered state only. There is no combinational path from in_ready or f_ack.
- 9th word accepted at edge N: out_ready=1 from cycle N+1.
- Last word accepted at slot k (cnt becomes k<9): PAD lasts 9-k cycles, and out_ready rises 9-k cycles after the last-word edge.
- f_ack sampled high in FULL at edge M: out_ready=0 from M+1, and a new word is accepted at edge M+1 at the earliest. A word presented with f_ack in the same cycle is not accepted.
- Sustained throughput: 1 block per 10 cycles (9 absorb + ≥1 FULL).

## Test plan
- Single short message: after reset, in=64'h90ABCDEF11111111, is_last=1, byte_num=3. Required: out_ready after 9 cycles, out[575:512]=64'h90ABCD0600000000, words 1..7 zero, out[63:0]=64'h0000000000000080, last_block=1.
- Full-rate tail: 8 words 64'h1111111111111111, then in=64'h0102030405060708, is_last=1, byte_num=7. Required: out_ready next cycle, out[63:0]=64'h0102030405060786, last_block=1, no PAD cycles.
- Exact-multiple message: 9 non-last words → out_ready, last_block=0; f_ack; then is_last with byte_num=0. Required: second block out[575:512]=64'h0600000000000000, out[63:0]=64'h80, last_block=1.
- Backpressure: hold in_ready=1 with a new word for 5 cycles while FULL. Required: buffer unchanged; after f_ack, out_ready=0 next cycle and the first word accepted one edge later.
- Spurious ack / drops: f_ack pulsed during ABSORB and PAD → cnt and buffer unaffected; in_ready during PAD → no change to padded result.
- Reset mid-PAD: assert reset 2 cycles after a last word at slot 3. Required: all outputs 0 asynchronously; a following 3-byte message produces the single-message result above.
